// File: rtl/ext_ram_arbiter.sv
// Round-robin arbiter sharing one external-RAM slave port among REQ_NUM requesters.
// Outstanding reads are tracked in an ID FIFO so read returns are steered back to their issuer.
module ext_ram_arbiter #(
    parameter int REQ_NUM          = 2,
    parameter int RAM_ADDR_WIDTH   = 20,
    parameter int DATA_WIDTH       = 32,
    parameter int MAX_PENDING_READ = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [REQ_NUM*RAM_ADDR_WIDTH-1:0] req_address,
    input  logic [REQ_NUM*4-1:0]              req_byteenable_n,
    input  logic [REQ_NUM*DATA_WIDTH-1:0]     req_writedata,
    input  logic [REQ_NUM-1:0]                req_read_n,
    input  logic [REQ_NUM-1:0]                req_write_n,
    output logic [REQ_NUM-1:0]                req_waitrequest,
    output logic [DATA_WIDTH-1:0]             req_readdata,
    output logic [REQ_NUM-1:0]                req_readdatavalid,
    output logic [RAM_ADDR_WIDTH-1:0]         ram_address,
    output logic [3:0]                        ram_byteenable_n,
    output logic                              ram_chipselect,
    output logic [DATA_WIDTH-1:0]             ram_writedata,
    output logic                              ram_read_n,
    output logic                              ram_write_n,
    input  logic [DATA_WIDTH-1:0]             ram_readdata,
    input  logic                              ram_readdatavalid,
    input  logic                              ram_waitrequest,
    output logic                              err_unexpected_rdv
);

    localparam int IDW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam int PW  = $clog2(MAX_PENDING_READ);
    localparam int CW  = PW + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0]   fifo_mem_q [MAX_PENDING_READ];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             err_q;

    logic             any_req;
    logic [IDW-1:0]   winner;
    logic             cmd_write, cmd_read, fifo_full;
    logic             issue_read, issuing, accept;
    logic             push, pop;
    logic [IDW-1:0]   head;

    // Round-robin search starting just above the last winner.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        winner  = ptr_q;
        any_req = ~&(req_read_n & req_write_n);
        for (int k = REQ_NUM; k >= 1; k--) begin
            int idx;
            idx = (int'(ptr_q) + k) % REQ_NUM;
            if (!req_read_n[idx] || !req_write_n[idx]) begin
                winner = IDW'(idx);
            end
        end
    end

    always_comb begin
        cmd_write  = (state_q == GRANT) && !req_write_n[gnt_q];
        cmd_read   = (state_q == GRANT) && !req_read_n[gnt_q] && !cmd_write;
        fifo_full  = (count_q == CW'(MAX_PENDING_READ));
        issue_read = cmd_read && !fifo_full;
        issuing    = cmd_write || issue_read;
        accept     = issuing && !ram_waitrequest;
        push       = issue_read && !ram_waitrequest;
        pop        = ram_readdatavalid && (count_q != '0);
        head       = fifo_mem_q[rd_ptr_q];
    end

    always_comb begin
        ram_write_n      = !cmd_write;
        ram_read_n       = !issue_read;
        ram_chipselect   = issuing;
        ram_address      = '0;
        ram_byteenable_n = 4'hF;
        ram_writedata    = '0;
        if (issuing) begin
            ram_address      = req_address[int'(gnt_q)*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
            ram_byteenable_n = req_byteenable_n[int'(gnt_q)*4 +: 4];
            ram_writedata    = req_writedata[int'(gnt_q)*DATA_WIDTH +: DATA_WIDTH];
        end

        req_waitrequest = '1;
        if (accept) begin
            req_waitrequest[gnt_q] = 1'b0;
        end

        for (int i = 0; i < REQ_NUM; i++) begin
            req_readdatavalid[i] = pop && (head == IDW'(i));
        end
    end

    assign req_readdata       = ram_readdata;
    assign err_unexpected_rdv = err_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = GRANT;
                    gnt_d   = winner;
                    ptr_d   = winner;
                end
            end
            GRANT: begin
                if (accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= IDW'(REQ_NUM - 1);
            gnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (ram_readdatavalid && (count_q == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    // NOTE: FIFO storage is not reset; entries are only read while count_q says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= gnt_q;
        end
    end

endmodule

// File: tb/tb_ext_ram_arbiter.sv
// Directed, table-driven bench for ext_ram_arbiter with two requesters.
// Each table row is one clock cycle: inputs driven after the falling edge, outputs compared 1 ns later.
module tb_ext_ram_arbiter;

    localparam logic [19:0] A0 = 20'h00010;
    localparam logic [19:0] A1 = 20'h00ABC;
    localparam logic [31:0] D0 = 32'hDEADBEEF;
    localparam logic [31:0] D1 = 32'hCAFEF00D;
    localparam logic [3:0]  B0 = 4'h0;
    localparam logic [3:0]  B1 = 4'h3;

    logic        clk;
    logic        reset;
    logic [39:0] req_address;
    logic [7:0]  req_byteenable_n;
    logic [63:0] req_writedata;
    logic [1:0]  req_read_n;
    logic [1:0]  req_write_n;
    logic [1:0]  req_waitrequest;
    logic [31:0] req_readdata;
    logic [1:0]  req_readdatavalid;
    logic [19:0] ram_address;
    logic [3:0]  ram_byteenable_n;
    logic        ram_chipselect;
    logic [31:0] ram_writedata;
    logic        ram_read_n;
    logic        ram_write_n;
    logic [31:0] ram_readdata;
    logic        ram_readdatavalid;
    logic        ram_waitrequest;
    logic        err_unexpected_rdv;

    ext_ram_arbiter #(
        .REQ_NUM(2), .RAM_ADDR_WIDTH(20), .DATA_WIDTH(32), .MAX_PENDING_READ(4)
    ) dut (
        .clk(clk), .reset(reset),
        .req_address(req_address), .req_byteenable_n(req_byteenable_n),
        .req_writedata(req_writedata), .req_read_n(req_read_n), .req_write_n(req_write_n),
        .req_waitrequest(req_waitrequest), .req_readdata(req_readdata),
        .req_readdatavalid(req_readdatavalid),
        .ram_address(ram_address), .ram_byteenable_n(ram_byteenable_n),
        .ram_chipselect(ram_chipselect), .ram_writedata(ram_writedata),
        .ram_read_n(ram_read_n), .ram_write_n(ram_write_n),
        .ram_readdata(ram_readdata), .ram_readdatavalid(ram_readdatavalid),
        .ram_waitrequest(ram_waitrequest), .err_unexpected_rdv(err_unexpected_rdv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected-output layout: {read_n, write_n, cs, addr, wdata, be_n, waitreq, rdv, rdata, err}
    typedef struct {
        logic [1:0]  rd_n;
        logic [1:0]  wr_n;
        logic        rwait;
        logic        rdv;
        logic [31:0] rdata;
        logic [95:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [95:0] outputs_now();
        return {ram_read_n, ram_write_n, ram_chipselect, ram_address, ram_writedata,
                ram_byteenable_n, req_waitrequest, req_readdatavalid, req_readdata,
                err_unexpected_rdv};
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_row(input logic [1:0] rd_n, input logic [1:0] wr_n, input logic rwait,
                           input logic rdv, input logic [31:0] rdata, input logic iss,
                           input logic is_wr, input logic req, input logic [1:0] wait_e,
                           input logic [1:0] rdv_e, input logic err_e);
        vec_t v;
        v.rd_n  = rd_n;
        v.wr_n  = wr_n;
        v.rwait = rwait;
        v.rdv   = rdv;
        v.rdata = rdata;
        if (iss)
            v.exp = {is_wr, !is_wr, 1'b1, req ? A1 : A0, req ? D1 : D0, req ? B1 : B0,
                     wait_e, rdv_e, rdata, err_e};
        else
            v.exp = {1'b1, 1'b1, 1'b0, 20'h0, 32'h0, 4'hF, 2'b11, rdv_e, rdata, err_e};
        vecs.push_back(v);
    endtask

    // RAM port quiet (IDLE, or GRANT stalled on a full FIFO).
    task automatic quiet(input logic [1:0] rd_n, input logic [1:0] wr_n, input logic rwait,
                         input logic rdv, input logic [31:0] rdata, input logic [1:0] rdv_e,
                         input logic err_e);
        add_row(rd_n, wr_n, rwait, rdv, rdata, 1'b0, 1'b0, 1'b0, 2'b11, rdv_e, err_e);
    endtask

    // Command from requester req issued on the RAM port.
    task automatic issue(input logic [1:0] rd_n, input logic [1:0] wr_n, input logic rwait,
                         input logic req, input logic is_wr, input logic [1:0] wait_e,
                         input logic err_e);
        add_row(rd_n, wr_n, rwait, 1'b0, 32'h0, 1'b1, is_wr, req, wait_e, 2'b00, err_e);
    endtask

    task automatic drive(input logic [1:0] rd_n, input logic [1:0] wr_n, input logic rwait,
                         input logic rdv, input logic [31:0] rdata);
        req_read_n        = rd_n;
        req_write_n       = wr_n;
        ram_waitrequest   = rwait;
        ram_readdatavalid = rdv;
        ram_readdata      = rdata;
    endtask

    initial begin
        req_address      = {A1, A0};
        req_byteenable_n = {B1, B0};
        req_writedata    = {D1, D0};
        reset            = 1'b1;
        drive(2'b11, 2'b11, 1'b0, 1'b0, 32'h0);

        // Round robin with both requesters reading; returns keep the FIFO from filling.
        quiet(2'b00, 2'b11, 0, 0, 32'h0, 2'b00, 0);
        issue(2'b00, 2'b11, 0, 0, 0, 2'b10, 0);
        quiet(2'b00, 2'b11, 0, 1, 32'hA0A0A0A0, 2'b01, 0);
        issue(2'b00, 2'b11, 0, 1, 0, 2'b01, 0);
        quiet(2'b00, 2'b11, 0, 1, 32'hB0B0B0B0, 2'b10, 0);
        issue(2'b00, 2'b11, 0, 0, 0, 2'b10, 0);
        quiet(2'b00, 2'b11, 0, 1, 32'hA1A1A1A1, 2'b01, 0);
        issue(2'b00, 2'b11, 0, 1, 0, 2'b01, 0);
        quiet(2'b11, 2'b11, 0, 1, 32'h0C0C0C0C, 2'b10, 0);
        // Requester 1 reads, then requester 0; returns steered in issue order.
        quiet(2'b01, 2'b11, 0, 0, 32'h0, 2'b00, 0);
        issue(2'b01, 2'b11, 0, 1, 0, 2'b01, 0);
        quiet(2'b10, 2'b11, 0, 0, 32'h0, 2'b00, 0);
        issue(2'b10, 2'b11, 0, 0, 0, 2'b10, 0);
        quiet(2'b11, 2'b11, 0, 1, 32'h11111111, 2'b10, 0);
        quiet(2'b11, 2'b11, 0, 1, 32'h22222222, 2'b01, 0);
        // Fill the FIFO with four reads, then a fifth stalls until the cycle after a pop.
        for (int k = 0; k < 4; k++) begin
            quiet(2'b10, 2'b11, 0, 0, 32'h0, 2'b00, 0);
            issue(2'b10, 2'b11, 0, 0, 0, 2'b10, 0);
        end
        quiet(2'b10, 2'b11, 0, 0, 32'h0, 2'b00, 0);
        quiet(2'b10, 2'b11, 0, 0, 32'h0, 2'b00, 0);
        quiet(2'b10, 2'b11, 0, 1, 32'h33333333, 2'b01, 0);
        issue(2'b10, 2'b11, 0, 0, 0, 2'b10, 0);
        // Write with three wait states while the FIFO is full.
        quiet(2'b11, 2'b01, 1, 0, 32'h0, 2'b00, 0);
        for (int k = 0; k < 3; k++) issue(2'b11, 2'b01, 1, 1, 1, 2'b11, 0);
        issue(2'b11, 2'b01, 0, 1, 1, 2'b01, 0);
        quiet(2'b11, 2'b11, 0, 0, 32'h0, 2'b00, 0);
        // Drain, then a spurious return.
        for (int k = 0; k < 4; k++) quiet(2'b11, 2'b11, 0, 1, 32'h44444440 + k, 2'b01, 0);
        quiet(2'b11, 2'b11, 0, 1, 32'h55555555, 2'b00, 0);
        quiet(2'b11, 2'b11, 0, 0, 32'h0, 2'b00, 1);
        quiet(2'b11, 2'b11, 0, 0, 32'h0, 2'b00, 1);
        // Read and write both low is a write.
        quiet(2'b10, 2'b10, 0, 0, 32'h0, 2'b00, 1);
        issue(2'b10, 2'b10, 0, 0, 1, 2'b10, 1);
        quiet(2'b11, 2'b11, 0, 0, 32'h0, 2'b00, 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_outputs", outputs_now(),
              {1'b1, 1'b1, 1'b0, 20'h0, 32'h0, 4'hF, 2'b11, 2'b00, 32'h0, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = 1'b0;
            drive(vecs[i].rd_n, vecs[i].wr_n, vecs[i].rwait, vecs[i].rdv, vecs[i].rdata);
            #1;
            check($sformatf("vec%0d", i), outputs_now(), vecs[i].exp);
        end

        // Reset clears the sticky error.
        @(negedge clk);
        reset = 1'b1;
        drive(2'b11, 2'b11, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        check("reset_clears_err", {94'h0, err_unexpected_rdv, req_waitrequest[0]}, {94'h0, 2'b01});

        // Reset in the middle of a grant with one read outstanding.
        @(negedge clk);
        reset = 1'b0;
        drive(2'b10, 2'b11, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        check("mo_read_issue", {95'h0, ram_read_n}, 96'h0);
        @(negedge clk);
        drive(2'b11, 2'b10, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        check("mo_write_held", {93'h0, ram_write_n, req_waitrequest}, {93'h0, 1'b0, 2'b11});
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive(2'b11, 2'b11, 1'b0, 1'b1, 32'h66666666);
        #1;
        check("mo_grant_dropped", {92'h0, ram_write_n, ram_chipselect, req_readdatavalid},
              {92'h0, 1'b1, 1'b0, 2'b00});
        @(negedge clk);
        drive(2'b11, 2'b11, 1'b0, 1'b0, 32'h0);
        #1;
        check("mo_stale_rdv_err", {95'h0, err_unexpected_rdv}, {95'h0, 1'b1});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ext_ram_arbiter.md
# ext_ram_arbiter

Round-robin arbiter that shares one external-RAM slave port (the 32-bit SRAM/SDRAM controller port driven by `ext_ram_nic`) among `REQ_NUM` Avalon-style requesters, e.g. the NIC and a local processor. It grants one requester at a time, forwards that requester's command to the RAM port, and tracks outstanding reads in an ID FIFO. Each `ram_readdatavalid` beat is steered back to the requester that issued the read.

## Interface
- `REQ_NUM`, 2: number of requesters (2..8).
- `RAM_ADDR_WIDTH`, 20: word address width.
- `DATA_WIDTH`, 32: data width.
- `MAX_PENDING_READ`, 4: outstanding-read FIFO depth (power of 2).
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `req_address` in `REQ_NUM*RAM_ADDR_WIDTH`: per-requester address, requester i at slice i.
- `req_byteenable_n` in `REQ_NUM*4`: per-requester active-low byte enables.
- `req_writedata` in `REQ_NUM*DATA_WIDTH`: per-requester write data.
- `req_read_n` in `REQ_NUM`: active-low read request, one bit per requester.
- `req_write_n` in `REQ_NUM`: active-low write request, one bit per requester.
- `req_waitrequest` out `REQ_NUM`: 1 = command not accepted this cycle.
- `req_readdata` out `DATA_WIDTH`: `ram_readdata` broadcast to all requesters.
- `req_readdatavalid` out `REQ_NUM`: one-hot read-return strobe.
- `ram_address` out `RAM_ADDR_WIDTH`.
- `ram_byteenable_n` out 4.
- `ram_chipselect` out 1.
- `ram_writedata` out `DATA_WIDTH`.
- `ram_read_n` out 1.
- `ram_write_n` out 1.
- `ram_readdata` in `DATA_WIDTH`.
- `ram_readdatavalid` in 1.
- `ram_waitrequest` in 1.
- `err_unexpected_rdv` out 1: sticky flag, set by a read return with no read outstanding.

## Operation
- Request from requester i: `req_read_n[i]==0` or `req_write_n[i]==0`. If both are low, the command is treated as a write.
- Requesters hold their command stable until they see their `req_waitrequest` bit at 0.
- FSM with two states, IDLE and GRANT.
- IDLE:
  - If any request is asserted, pick the winner by round-robin, searching upward from `ptr+1` modulo `REQ_NUM`.
  - Register the winner in `gnt_id`, set `ptr <= winner`, and go to GRANT.
  - If no request is asserted, stay in IDLE.
- GRANT, combinational forwarding from requester `gnt_id` to the RAM port:
  - Address, byte enables and write data are forwarded.
  - `ram_write_n = req_write_n[gnt_id]`.
  - `ram_read_n = req_read_n[gnt_id]`, except it is forced to 1 when the command is a write or when the FIFO is full.
  - `ram_chipselect` = a read or write is being issued this cycle.
- Accept: the issued command sees `ram_waitrequest==0`. On accept, `req_waitrequest[gnt_id]=0` for that cycle and the FSM goes back to IDLE next cycle.
- Read stalled on a full FIFO: `req_waitrequest[gnt_id]=1`, `ram_read_n=1`, and the FSM stays in GRANT.
- Every non-granted requester sees `req_waitrequest=1`.
- Outstanding-read FIFO stores `gnt_id`, width `clog2(REQ_NUM)`, with a count register of `clog2(MAX_PENDING_READ)+1` bits:
  - Push on each accepted read.
  - Pop on each `ram_readdatavalid`.
  - Push and pop in the same cycle leave the count unchanged.
- Read return: `req_readdatavalid[i] = ram_readdatavalid && count!=0 && head==i`.
- Full is evaluated on the registered count, so a pop in the same cycle does not unblock a stalled read until the next cycle.
- `ram_readdatavalid` with count==0: no `req_readdatavalid` bit is asserted, no pop occurs, and `err_unexpected_rdv` is set until reset.
- Writes are never blocked by FIFO state.
- RAM port when not issuing: address, byte enables and write data are driven to 0; `ram_byteenable_n` is driven to `4'hF`.

## Timing
- Reset values:
  - FSM in IDLE.
  - `ptr = REQ_NUM-1`, so requester 0 has first priority.
  - FIFO empty.
  - `ram_read_n = 1`, `ram_write_n = 1`, `ram_chipselect = 0`.
  - `req_waitrequest` all 1s, `req_readdatavalid` all 0s, `err_unexpected_rdv = 0`.
- Reset mid-operation: the grant is dropped and outstanding reads are discarded. Read returns arriving after reset set the error flag.
- Grant latency: a request first seen in IDLE at cycle t is granted at t+1. With `ram_waitrequest=0`, accept happens at t+1.
- Throughput: at most one command per 2 cycles.
- `ram_waitrequest` is passed through combinationally to the granted requester.
- Read-return steering is combinational, with zero added latency.

## Test plan
- Single write: requester 0 writes addr 0x00010, data 0xDEADBEEF, `ram_waitrequest=0`. Required: `ram_write_n=0` at cycle 1, `req_waitrequest[0]=0` at cycle 1, and IDLE at cycle 2.
- Round-robin: both requesters read continuously, `MAX_PENDING_READ` not reached. Required: grant order 0,1,0,1 and each requester gets 1 of every 4 cycles.
- Read return routing: requester 1 reads A, then requester 0 reads B, with RAM returns 0x11111111 then 0x22222222. Required: `req_readdatavalid` = 2'b10 then 2'b01, with matching data.
- FIFO full: 4 reads accepted with no returns, then a 5th read. Required: 5th read stalled (`ram_read_n=1`). Then one return. Required: 5th read accepted the cycle after the pop.
- Wait states: `ram_waitrequest=1` for 3 cycles during a write. Required: command held stable, FSM stays in GRANT, accept in the 4th cycle.
- Spurious return: `ram_readdatavalid` with FIFO empty. Required: `err_unexpected_rdv=1` from the next cycle until reset, and no `req_readdatavalid` bit asserted.
